// File: rtl/input_conditioner.sv
// input_conditioner: board-pin front end for the reaction game.
// Synchronizes and debounces the go/reset buttons and the 16 slide switches,
// then turns accepted edges into single-cycle command pulses, stable switch
// levels and per-switch change strobes for state_manager.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_go,
    input  logic        btn_reset,
    input  logic [15:0] sw_raw,
    output logic        go,
    output logic        resetGame,
    output logic        resetAll,
    output logic [15:0] switches,
    output logic [15:0] sw_changed
);

    // Channel map: [15:0] switches, [16] go button, [17] reset button
    localparam int NCH    = 18;
    localparam int CH_GO  = 16;
    localparam int CH_RST = 17;

    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } rst_state_t;

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] sync1_reg;
    logic [NCH-1:0] sync2_reg;

    logic [TW-1:0]  tick_cnt_reg;
    logic           tick;

    logic [NCH-1:0] sample_reg;
    logic [NCH-1:0] sample_next;
    logic [NCH-1:0] stable_reg;
    logic [NCH-1:0] stable_next;
    logic [NCH-1:0] stable_prev_reg;

    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;

    logic           go_reg;
    logic [15:0]    sw_changed_reg;

    rst_state_t     state_reg;
    logic [HW-1:0]  hold_cnt_reg;
    logic           reset_game_reg;
    logic           reset_all_reg;

    assign raw_vec = {btn_reset, btn_go, sw_raw};

    // Two-flop synchronizer on every raw pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    // Free-running sample-tick counter, wraps after DEBOUNCE_CYCLES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Per-channel debounce: a level is accepted once two consecutive ticks agree
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_debounce
            assign sample_next[gi] = tick ? sync2_reg[gi] : sample_reg[gi];
            assign stable_next[gi] = (tick && (sync2_reg[gi] == sample_reg[gi])
                                      && (sync2_reg[gi] != stable_reg[gi]))
                                     ? sync2_reg[gi] : stable_reg[gi];
        end
    endgenerate

    // Debounce state and previous-cycle copy of the accepted levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg      <= '0;
            stable_reg      <= '0;
            stable_prev_reg <= '0;
        end else begin
            sample_reg      <= sample_next;
            stable_reg      <= stable_next;
            stable_prev_reg <= stable_reg;
        end
    end

    assign rise = stable_reg & ~stable_prev_reg;
    assign fall = ~stable_reg & stable_prev_reg;

    // Registered edge strobes for the go button and the switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_reg         <= 1'b0;
            sw_changed_reg <= '0;
        end else begin
            go_reg         <= rise[CH_GO];
            sw_changed_reg <= stable_reg[15:0] ^ stable_prev_reg[15:0];
        end
    end

    // Reset-button press classifier: short press -> resetGame on release,
    // long press -> resetAll once the hold counter reaches its threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            reset_game_reg <= 1'b0;
            reset_all_reg  <= 1'b0;
        end else begin
            reset_game_reg <= 1'b0;
            reset_all_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    hold_cnt_reg <= '0;
                    if (rise[CH_RST]) begin
                        state_reg <= SHORT;
                    end
                end
                SHORT: begin
                    if (fall[CH_RST]) begin
                        reset_game_reg <= 1'b1;
                        hold_cnt_reg   <= '0;
                        state_reg      <= IDLE;
                    end else if (hold_cnt_reg == HOLD_LAST) begin
                        // Counter saturates here for the rest of the press
                        reset_all_reg <= 1'b1;
                        state_reg     <= LONG;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                LONG: begin
                    if (fall[CH_RST]) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    hold_cnt_reg <= '0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign go         = go_reg;
    assign resetGame  = reset_game_reg;
    assign resetAll   = reset_all_reg;
    assign switches   = stable_reg[15:0];
    assign sw_changed = sw_changed_reg;

endmodule
